// File: rtl/atm_io_pkg.sv
// rtl/atm_io_pkg.sv - shared ATM board I/O types, polarity constant and ms-to-cycle helper
package atm_io_pkg;

  // Beep sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } beep_state_t;

  // Buzzer/LED pin sounds when driven low
  localparam logic BUZZ_ACTIVE = 1'b0;

  // Converts a millisecond duration into clock cycles (also used by the debouncer)
  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz, input int unsigned ms);
    return (clk_hz / 1000) * ms;
  endfunction

endpackage

// File: rtl/ms_timer.sv
// rtl/ms_timer.sv - loadable down-counter that stops at zero and flags it
module ms_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority; otherwise count down and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/beep_alert_driver.sv
// rtl/beep_alert_driver.sv - turns event pulses into N timed beeps on an active-low buzzer pin
module beep_alert_driver
  import atm_io_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned ON_MS  = 50,
  parameter int unsigned OFF_MS = 50,
  parameter int          CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [CNT_W-1:0] count,
  input  logic             cancel,
  output logic             busy,
  output logic             buzz_n,
  output logic             done,
  output logic             dropped
);

  localparam int unsigned ON_CYC  = ms_to_cycles(CLK_HZ, ON_MS);
  localparam int unsigned OFF_CYC = ms_to_cycles(CLK_HZ, OFF_MS);
  localparam int unsigned PH_MAX  = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  // A one-cycle phase still needs a one-bit counter
  localparam int          PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0] ON_LOAD  = PH_W'(ON_CYC - 1);
  localparam logic [PH_W-1:0] OFF_LOAD = PH_W'(OFF_CYC - 1);

  generate
    if (ON_CYC == 0 || OFF_CYC == 0) begin : g_bad_timing
      $error("beep_alert_driver: ON/OFF phase length rounds to zero cycles");
    end
  endgenerate

  beep_state_t      state;
  logic [CNT_W-1:0] remaining;
  logic             ph_load;
  logic [PH_W-1:0]  ph_val;
  logic             ph_zero;

  ms_timer #(.W(PH_W)) u_phase (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ph_load),
    .load_val (ph_val),
    .zero     (ph_zero)
  );

  // Phase timer reload at each phase entry; cleared on cancel so IDLE always sees zero
  always_comb begin
    ph_load = 1'b0;
    ph_val  = '0;
    case (state)
      ST_IDLE: begin
        if (req && count != '0) begin
          ph_load = 1'b1;
          ph_val  = ON_LOAD;
        end
      end
      ST_ON: begin
        if (cancel) begin
          ph_load = 1'b1;
        end else if (ph_zero && remaining > CNT_W'(1)) begin
          ph_load = 1'b1;
          ph_val  = OFF_LOAD;
        end
      end
      ST_OFF: begin
        if (cancel) begin
          ph_load = 1'b1;
        end else if (ph_zero) begin
          ph_load = 1'b1;
          ph_val  = ON_LOAD;
        end
      end
      default: begin
        ph_load = 1'b1;
      end
    endcase
  end

  // Sequencer with registered outputs; done/dropped default to single-cycle pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      buzz_n    <= ~BUZZ_ACTIVE;
      done      <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      done    <= 1'b0;
      dropped <= 1'b0;
      case (state)
        ST_IDLE: begin
          // cancel is meaningless here; a request always takes priority
          if (req) begin
            if (count != '0) begin
              state     <= ST_ON;
              remaining <= count;
              busy      <= 1'b1;
              buzz_n    <= BUZZ_ACTIVE;
            end else begin
              dropped <= 1'b1;
            end
          end
        end
        ST_ON, ST_OFF: begin
          // Requests are never queued behind a running sequence
          dropped <= req;
          if (cancel) begin
            state     <= ST_IDLE;
            remaining <= '0;
            busy      <= 1'b0;
            buzz_n    <= ~BUZZ_ACTIVE;
            done      <= 1'b1;
          end else if (ph_zero) begin
            if (state == ST_OFF) begin
              state  <= ST_ON;
              buzz_n <= BUZZ_ACTIVE;
            end else if (remaining > CNT_W'(1)) begin
              state     <= ST_OFF;
              remaining <= remaining - 1'b1;
              buzz_n    <= ~BUZZ_ACTIVE;
            end else begin
              // Last beep ends straight into IDLE with no trailing gap
              state     <= ST_IDLE;
              remaining <= '0;
              busy      <= 1'b0;
              buzz_n    <= ~BUZZ_ACTIVE;
              done      <= 1'b1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          remaining <= '0;
          busy      <= 1'b0;
          buzz_n    <= ~BUZZ_ACTIVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beep_alert_driver.sv
// tb/tb_beep_alert_driver.sv - directed and random checks of beep_alert_driver against a timeline model
module tb_beep_alert_driver;

  localparam int ON_C  = 3;
  localparam int OFF_C = 2;
  localparam int PER   = ON_C + OFF_C;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [3:0] count;
  logic       cancel;
  logic       busy;
  logic       buzz_n;
  logic       done;
  logic       dropped;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;

  // Reference: the running sequence is described by its request cycle and last busy cycle
  bit active    = 1'b0;
  int seq_start = 0;
  int seq_end   = 0;
  int done_at   = -1;
  int drop_at   = -1;

  beep_alert_driver #(
    .CLK_HZ (1000),
    .ON_MS  (3),
    .OFF_MS (2),
    .CNT_W  (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .count   (count),
    .cancel  (cancel),
    .busy    (busy),
    .buzz_n  (buzz_n),
    .done    (done),
    .dropped (dropped)
  );

  always #5 clk = ~clk;

  function automatic bit exp_busy(input int c);
    return active && (c > seq_start) && (c <= seq_end);
  endfunction

  function automatic bit exp_buzz_n(input int c);
    if (!exp_busy(c)) return 1'b1;
    return !(((c - seq_start - 1) % PER) < ON_C);
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cyc_n, obs, exp);
    end
  endtask

  // Check the current cycle, apply inputs, advance the model, move to the next cycle
  task automatic step(input bit r, input logic [3:0] n, input bit c);
    bit eb;
    eb = exp_busy(cyc_n);
    chk("busy", busy, eb);
    chk("buzz_n", buzz_n, exp_buzz_n(cyc_n));
    chk("done", done, cyc_n == done_at);
    chk("dropped", dropped, cyc_n == drop_at);
    req    = r;
    count  = n;
    cancel = c;
    if (eb) begin
      if (c) begin
        seq_end = cyc_n;
        done_at = cyc_n + 1;
      end
      if (r) drop_at = cyc_n + 1;
    end else if (r) begin
      if (n != 0) begin
        active    = 1'b1;
        seq_start = cyc_n;
        seq_end   = cyc_n + int'(n) * ON_C + (int'(n) - 1) * OFF_C;
        done_at   = seq_end + 1;
      end else begin
        drop_at = cyc_n + 1;
      end
    end
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 4'd0, 1'b0);
  endtask

  initial begin
    logic [3:0] rn;
    rst_n  = 1'b0;
    req    = 1'b0;
    count  = 4'd0;
    cancel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_buzz_n", buzz_n, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_dropped", dropped, 1'b0);
    rst_n = 1'b1;

    idle(10);

    // Three beeps, full timeline
    step(1'b1, 4'd3, 1'b0);
    idle(16);

    // Single beep with a rejected request two cycles later
    step(1'b1, 4'd1, 1'b0);
    idle(1);
    step(1'b1, 4'd5, 1'b0);
    idle(6);

    // Four beeps cancelled in the second OFF gap
    step(1'b1, 4'd4, 1'b0);
    idle(8);
    step(1'b0, 4'd0, 1'b1);
    idle(10);

    // Zero-count request, then cancel alone in IDLE, then req+cancel together in IDLE
    step(1'b1, 4'd0, 1'b0);
    idle(3);
    step(1'b0, 4'd0, 1'b1);
    idle(2);
    step(1'b1, 4'd1, 1'b1);
    idle(6);

    // req and cancel together while busy
    step(1'b1, 4'd2, 1'b0);
    idle(2);
    step(1'b1, 4'd3, 1'b1);
    idle(4);

    // Asynchronous reset in the middle of an ON phase
    step(1'b1, 4'd2, 1'b0);
    idle(1);
    chk("pre_rst_buzz_n", buzz_n, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_buzz_n", buzz_n, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    cyc_n++;
    active  = 1'b0;
    done_at = -1;
    drop_at = -1;
    idle(3);

    // Back-to-back: re-request exactly in the done cycle
    step(1'b1, 4'd2, 1'b0);
    idle(8);
    step(1'b1, 4'd2, 1'b0);
    idle(12);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      rn = 4'($urandom_range(0, 4));
      step($urandom_range(0, 7) == 0, rn, $urandom_range(0, 29) == 0);
    end
    idle(30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
